mdu_controller: RTL
===================

// Module: mdu_controller
// PURPOSE
//   Multiply/divide unit sequencer for the MIPS core: accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO
//   from the execute stage, models fixed multi-cycle latency with a busy counter, and owns
//   the HI/LO registers. Provides the stall request the hazard unit uses to hold MFHI/MFLO and
//   new MDU ops while an operation is in flight.
// PARAMETERS
//   MULT_CYCLES  5   busy cycles for MULT/MULTU (>=1)
//   DIV_CYCLES   10  busy cycles for DIV/DIVU (>=1)
// PORTS
//   clk        in   1   clock, rising edge
//   reset      in   1   asynchronous, active-high; clears all state
//   start      in   1   op valid this cycle
//   op         in   3   0 NONE,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MTHI,6 MTLO,7 reserved(=NONE)
//   operand_a  in   32  rs value (multiplicand/dividend/MTHI-MTLO source)
//   operand_b  in   32  rt value (multiplier/divisor)
//   busy       out  1   operation in flight
//   stall      out  1   busy | (start & op in 1..4); hazard unit stalls MFHI/MFLO/MDU ops on it
//   done       out  1   one-cycle pulse on the cycle HI/LO take a mult/div result
//   hi         out  32  HI register
//   lo         out  32  LO register
// BEHAVIOUR
//   - Reset (async): state=IDLE, count=0, busy=0, done=0, hi=0, lo=0 (div0=0 if enabled).
//   - States: IDLE, RUN. Counter 4-bit min, sized to max(MULT_CYCLES,DIV_CYCLES).
//   - IDLE & start & op in 1..4: latch op/operands, count<=N (MULT_CYCLES or DIV_CYCLES), -> RUN.
//     busy rises the edge after start and stays high exactly N cycles.
//   - RUN: count decrements each cycle; on the edge where count==1: hi/lo <= result, done=1 for the
//     following cycle, busy=0, -> IDLE. New op accepted the cycle busy is low (back-to-back ok).
//   - start while busy: ignored (upstream is stalled; bench must never rely on acceptance).
//   - MTHI/MTLO in IDLE: hi (resp. lo) <= operand_a at next edge, no busy, no done; ignored when busy.
//   - op NONE/7 with start: no effect.
//   - MULT: {hi,lo} = signed 32x32 -> 64 product; MULTU unsigned.
//   - DIV: lo = quotient truncated toward zero, hi = remainder with dividend's sign (signed);
//     DIVU unsigned. Result computed from operands latched at start.
//   - DIV/DIVU with operand_b==0: full DIV_CYCLES latency, hi/lo unchanged, done still pulses.
//   - 0x80000000 / -1 (DIV): lo=0x80000000, hi=0.
//   - reset mid-RUN: operation discarded, outputs at reset values immediately.
// CONFIGURATION
//   MDU_DIV0_FLAG_EN defined: extra output port div0 (1 bit): set at the completion edge of a
//     DIV/DIVU with divisor 0, sticky until reset; division by zero still leaves hi/lo unchanged.
//   Not defined: no div0 port, no flag logic; all other behaviour identical.
// TESTING
//   1 reset asserted mid-RUN (cycle 3 of DIV) -> busy=0, hi=lo=0 same cycle, no done afterwards.
//   2 MULT a=0xFFFFFFFE(-2) b=3 -> busy high 5 cycles, then hi=0xFFFFFFFF lo=0xFFFFFFFA, done 1 cycle.
//   3 MULTU a=0xFFFFFFFF b=2 -> hi=0x00000001 lo=0xFFFFFFFE after 5 cycles.
//   4 DIV a=-7 b=2 -> after 10 cycles lo=0xFFFFFFFD(-3) hi=0xFFFFFFFF(-1); DIVU 7/2 -> lo=3 hi=1.
//   5 MTHI 0x12345678 then MTLO 0x9ABCDEF0 in IDLE -> hi/lo updated next edge, busy stays 0;
//     MTHI during RUN -> hi unchanged.
//   6 DIV a=5 b=0 after hi=1,lo=2 -> hi=1 lo=2 after 10 cycles, done pulses; with
//     MDU_DIV0_FLAG_EN div0=1 and remains 1 through a following MULT.

Source files
------------

// File: rtl/mdu_controller.sv
// -----------------------------------------------------------------------------
// mdu_controller
//   Multiply/divide sequencer for the MIPS core. It accepts MULT/MULTU/DIV/DIVU
//   and MTHI/MTLO from the execute stage and owns the HI/LO registers. A busy
//   counter models the fixed multi-cycle latency. The hazard unit uses the
//   stall output to hold MFHI/MFLO and new MDU ops while an operation is in
//   flight.
//
//   Parameters
//     MULT_CYCLES  busy cycles for MULT/MULTU (>=1)
//     DIV_CYCLES   busy cycles for DIV/DIVU   (>=1)
//
//   Ports
//     clk        in   1   clock, rising edge
//     reset      in   1   asynchronous, active-high; clears all state
//     start      in   1   op valid this cycle
//     op         in   3   0 NONE,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MTHI,6 MTLO,7 NONE
//     operand_a  in   32  rs value (multiplicand / dividend / MTHI-MTLO source)
//     operand_b  in   32  rt value (multiplier / divisor)
//     busy       out  1   operation in flight
//     stall      out  1   busy | (start & op is MULT/MULTU/DIV/DIVU)
//     done       out  1   one-cycle pulse when HI/LO take a mult/div result
//     hi, lo     out  32  HI / LO registers
//     div0       out  1   (only with MDU_DIV0_FLAG_EN) sticky divide-by-zero flag
//
//   Optional feature macro: MDU_DIV0_FLAG_EN
// -----------------------------------------------------------------------------
module mdu_controller #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
`ifdef MDU_DIV0_FLAG_EN
  ,
  output logic        div0
`endif
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW_RAW     = $clog2(MAX_CYCLES + 1);
  localparam int CW         = (CW_RAW < 4) ? 4 : CW_RAW;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q;
  logic [CW-1:0] count_q;
  logic [2:0]    op_q;
  logic [31:0]   a_q, b_q;
  logic [31:0]   hi_q, lo_q;
  logic          busy_q, done_q;

  logic          start_mdu;
  logic          div_by_zero;
  logic [63:0]   prod_s, prod_u;
  logic [31:0]   hi_d, lo_d;

  assign start_mdu   = start && (op >= OP_MULT) && (op <= OP_DIVU);
  assign div_by_zero = (b_q == 32'd0);

  // Result is formed from the operands latched at start, so upstream may
  // change operand_a/operand_b freely while the op is in flight.
  assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    case (op_q)
      OP_MULT:  {hi_d, lo_d} = prod_s;
      OP_MULTU: {hi_d, lo_d} = prod_u;
      OP_DIV: begin
        if (!div_by_zero) begin
          // The most negative value divided by -1 overflows; architecturally
          // the quotient wraps back to itself with a zero remainder.
          if (a_q == 32'h8000_0000 && b_q == 32'hFFFF_FFFF) begin
            lo_d = 32'h8000_0000;
            hi_d = 32'd0;
          end else begin
            lo_d = $signed(a_q) / $signed(b_q);
            hi_d = $signed(a_q) % $signed(b_q);
          end
        end
      end
      OP_DIVU: begin
        if (!div_by_zero) begin
          lo_d = a_q / b_q;
          hi_d = a_q % b_q;
        end
      end
      default: ;
    endcase
  end

`ifdef MDU_DIV0_FLAG_EN
  logic div0_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      op_q    <= 3'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef MDU_DIV0_FLAG_EN
      div0_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                op_q    <= op;
                a_q     <= operand_a;
                b_q     <= operand_b;
                count_q <= (op == OP_MULT || op == OP_MULTU) ? CW'(MULT_CYCLES)
                                                             : CW'(DIV_CYCLES);
                busy_q  <= 1'b1;
                state_q <= RUN;
              end
              OP_MTHI: hi_q <= operand_a;
              OP_MTLO: lo_q <= operand_a;
              default: ;
            endcase
          end
        end
        RUN: begin
          // New requests are ignored here; the hazard unit holds them upstream.
          if (count_q == CW'(1)) begin
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            count_q <= '0;
            state_q <= IDLE;
`ifdef MDU_DIV0_FLAG_EN
            if ((op_q == OP_DIV || op_q == OP_DIVU) && div_by_zero)
              div0_q <= 1'b1;
`endif
          end else begin
            count_q <= count_q - CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy  = busy_q;
  assign stall = busy_q | start_mdu;
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;
`ifdef MDU_DIV0_FLAG_EN
  assign div0  = div0_q;
`endif

endmodule
